// File: rtl/gbc_oam_dma.sv
// gbc_oam_dma: OAM DMA engine for $FF46, copies OamBytes bytes from {Base,00} into OAM.
// Echo-RAM sources (E0-FF) fold down by 20h; a write while busy restarts the transfer.
module gbc_oam_dma #(
    parameter string DeviceType = "Xilinx",
    parameter int    OamBytes   = 160
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        ClkEn,
    input  logic        RegWrite,
    input  logic [7:0]  RegDin,
    output logic [7:0]  RegDout,
    output logic        Busy,
    output logic [15:0] SrcAddress,
    output logic        SrcAccess,
    output logic        SrcWrite,
    input  logic [7:0]  SrcDin,
    input  logic        SrcReady,
    input  logic        SrcDataReady,
    output logic [7:0]  OamAddress,
    output logic        OamWrite,
    output logic [7:0]  OamDout
);
    localparam logic [7:0] LAST = 8'(OamBytes - 1);

    typedef enum logic [2:0] {IDLE, START, REQ, WAIT, WR} state_t;

    state_t     state, state_nxt;
    logic [7:0] reg_q, base_q, idx_q, dout_q;
    logic       last, capture;

    if (DeviceType != "Xilinx") begin : g_generic
    end

    always_comb begin
        last = idx_q == LAST;
        capture = !RegWrite && ((state == REQ && SrcReady && SrcDataReady) || (state == WAIT && SrcDataReady));
        state_nxt = state;
        if (RegWrite)
            state_nxt = START;
        else
            case (state)
                IDLE:    state_nxt = IDLE;
                START:   state_nxt = REQ;
                REQ:     state_nxt = SrcReady ? (SrcDataReady ? WR : WAIT) : REQ;
                WAIT:    state_nxt = SrcDataReady ? WR : WAIT;
                WR:      state_nxt = last ? IDLE : REQ;
                default: state_nxt = IDLE;
            endcase
    end

    always_ff @(posedge Clk)
        if (Reset) begin
            state  <= IDLE;
            reg_q  <= '0;
            base_q <= '0;
            idx_q  <= '0;
            dout_q <= '0;
        end else if (ClkEn) begin
            state <= state_nxt;
            if (RegWrite) begin
                reg_q  <= RegDin;
                base_q <= RegDin >= 8'hE0 ? RegDin - 8'h20 : RegDin;
                idx_q  <= '0;
            end else if (state == WR && !last)
                idx_q <= idx_q + 8'd1;
            if (capture)
                dout_q <= SrcDin;
        end

    // a restart landing on the WR cycle drops that byte's write
    assign OamWrite   = state == WR && !RegWrite;
    assign Busy       = state != IDLE;
    assign SrcAccess  = state == REQ;
    assign SrcWrite   = 1'b0;
    assign SrcAddress = {base_q, idx_q};
    assign OamAddress = idx_q;
    assign OamDout    = dout_q;
    assign RegDout    = reg_q;
endmodule

// File: tb/tb_gbc_oam_dma.sv
// tb_gbc_oam_dma: directed transfers against a memory-bus responder and an OAM image model.
module tb_gbc_oam_dma;
    logic        Clk = 1'b0;
    logic        Reset, ClkEn, RegWrite, SrcReady, SrcDataReady;
    logic [7:0]  RegDin, SrcDin, RegDout, OamAddress, OamDout;
    logic        Busy, SrcAccess, SrcWrite, OamWrite;
    logic [15:0] SrcAddress;

    always #5 Clk = ~Clk;

    gbc_oam_dma dut (
        .Clk(Clk), .Reset(Reset), .ClkEn(ClkEn), .RegWrite(RegWrite), .RegDin(RegDin),
        .RegDout(RegDout), .Busy(Busy), .SrcAddress(SrcAddress), .SrcAccess(SrcAccess),
        .SrcWrite(SrcWrite), .SrcDin(SrcDin), .SrcReady(SrcReady), .SrcDataReady(SrcDataReady),
        .OamAddress(OamAddress), .OamWrite(OamWrite), .OamDout(OamDout)
    );

    int errors = 0, checks = 0;
    logic [7:0]  key;
    logic [7:0]  oam_mem [256];
    logic [15:0] reads [$];
    int wr_cnt = 0, cyc_n = 0, first_wr = -1, last_wr = -1, t0 = 0;
    bit pend = 0, rnd_mode = 0, sc = 0, prev_st = 0;
    logic [15:0] pend_addr, prev_addr;
    int pend_dly = 0, rq_wait = 0, rdy_stall = 0, dat_stall = 0;
    int stall_err = 0, busy_drop = 0, freeze_err = 0, n_hold;
    logic [42:0] snap;

    function automatic logic [7:0] bus_data(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ key;
    endfunction

    function automatic logic [7:0] fold(input logic [7:0] v);
        return v >= 8'hE0 ? v - 8'h20 : v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: drive bus response, observe, commit bus state, advance to next negedge
    task automatic cyc();
        SrcReady = 0; SrcDataReady = 0; SrcDin = 0; sc = 0;
        if (pend) begin
            if (pend_dly == 0) begin SrcDataReady = 1; SrcDin = bus_data(pend_addr); end
        end else if (SrcAccess && rq_wait == 0) begin
            SrcReady = 1;
            sc = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b0;
            if (sc) begin SrcDataReady = 1; SrcDin = bus_data(SrcAddress); end
        end
        #1;
        if (ClkEn && !Reset) begin
            if (OamWrite) begin
                oam_mem[OamAddress] = OamDout;
                wr_cnt++;
                if (first_wr < 0) first_wr = cyc_n;
                last_wr = cyc_n;
            end
            if (SrcAccess && !SrcReady) begin
                if (prev_st && SrcAddress !== prev_addr) stall_err++;
                prev_st = 1; prev_addr = SrcAddress;
            end else prev_st = 0;
            if (pend) begin
                if (pend_dly == 0) pend = 0; else pend_dly--;
            end else if (SrcAccess) begin
                if (rq_wait > 0) rq_wait--;
                else begin
                    reads.push_back(SrcAddress);
                    if (!sc) begin
                        pend = 1; pend_addr = SrcAddress;
                        pend_dly = rnd_mode ? int'($urandom_range(0, 3)) : dat_stall;
                    end
                    rq_wait = rnd_mode ? int'($urandom_range(0, 3)) : rdy_stall;
                end
            end
            cyc_n++;
        end
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic start(input logic [7:0] v);
        for (int n = 0; n < 256; n++) oam_mem[n] = ~bus_data({fold(v), 8'(n)});
        wr_cnt = 0; first_wr = -1; last_wr = -1; t0 = cyc_n; rq_wait = rdy_stall;
        RegWrite = 1; RegDin = v;
        cyc();
        RegWrite = 0;
        reads.delete();
    endtask

    task automatic wait_writes(input string tag, input int n);
        int b = 0;
        while (wr_cnt < n && b < 20000) begin
            if (!Busy) busy_drop++;
            cyc();
            b++;
        end
        check({tag, "_timeout"}, 32'(wr_cnt >= n), 1);
    endtask

    task automatic check_xfer(input string tag, input logic [7:0] v);
        int bad = 0;
        for (int n = 0; n < 160; n++) if (oam_mem[n] !== bus_data({fold(v), 8'(n)})) bad++;
        check({tag, "_oam"}, bad, 0);
        check({tag, "_nreads"}, reads.size(), 160);
        bad = 0;
        foreach (reads[i]) if (reads[i] !== {fold(v), 8'(i)}) bad++;
        check({tag, "_raddr"}, bad, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        Reset = 1; ClkEn = 1; RegWrite = 0; RegDin = 0; SrcReady = 0; SrcDataReady = 0; SrcDin = 0;
        key = 8'($urandom);
        @(negedge Clk);
        idle(2);
        Reset = 0;
        check("rst_busy", Busy, 0);
        check("rst_srcaccess", SrcAccess, 0);
        check("rst_oamwrite", OamWrite, 0);
        check("rst_regdout", RegDout, 0);
        check("rst_srcaddr", SrcAddress, 0);
        check("rst_oamaddr", OamAddress, 0);
        check("rst_oamdout", OamDout, 0);
        check("rst_srcwrite", SrcWrite, 0);
        idle(10);
        check("idle_writes", wr_cnt, 0);
        check("idle_busy", Busy, 0);
        check("idle_regdout", RegDout, 0);

        key = 8'($urandom); busy_drop = 0;
        start(8'hC1);
        check("t2_busy", Busy, 1);
        wait_writes("t2", 160);
        check("t2_busy_fall", Busy, 0);
        check("t2_first", first_wr - t0, 4);
        check("t2_last", last_wr - t0, 4 + 3 * 159);
        check_xfer("t2", 8'hC1);
        idle(5);
        check("t2_count", wr_cnt, 160);
        check("t2_busy_drop", busy_drop, 0);

        key = 8'($urandom); rdy_stall = 3; dat_stall = 2; stall_err = 0;
        start(8'hC1);
        wait_writes("t3", 160);
        check("t3_busy_fall", Busy, 0);
        check_xfer("t3", 8'hC1);
        idle(5);
        check("t3_count", wr_cnt, 160);
        check("t3_stable", stall_err, 0);

        key = 8'($urandom); rdy_stall = 0; dat_stall = 0; busy_drop = 0;
        start(8'h80);
        wait_writes("t4a", 50);
        start(8'hC0);
        wait_writes("t4", 160);
        check("t4_first", first_wr - t0, 4);
        check_xfer("t4", 8'hC0);
        check("t4_regdout", RegDout, 8'hC0);
        check("t4_busy_drop", busy_drop, 0);

        key = 8'($urandom);
        start(8'hFE);
        check("t5_regdout", RegDout, 8'hFE);
        wait_writes("t5", 160);
        check("t5_busy_fall", Busy, 0);
        check_xfer("t5", 8'hFE);

        key = 8'($urandom);
        start(8'hC1);
        wait_writes("t6", 71);
        Reset = 1;
        cyc();
        Reset = 0; pend = 0; rq_wait = 0;
        check("t6_busy", Busy, 0);
        check("t6_srcaccess", SrcAccess, 0);
        check("t6_oamwrite", OamWrite, 0);
        n_hold = wr_cnt;
        idle(20);
        check("t6_no_writes", wr_cnt, n_hold);

        key = 8'($urandom); rdy_stall = 1; dat_stall = 1;
        start(8'hC3);
        wait_writes("t6f", 30);
        cyc();
        snap = {Busy, SrcAccess, OamWrite, SrcAddress, OamAddress, OamDout, RegDout};
        ClkEn = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if ({Busy, SrcAccess, OamWrite, SrcAddress, OamAddress, OamDout, RegDout} !== snap) freeze_err++;
        end
        ClkEn = 1;
        check("t6_freeze", freeze_err, 0);
        wait_writes("t6f", 160);
        check_xfer("t6f", 8'hC3);

        key = 8'($urandom); rdy_stall = 0; dat_stall = 0;
        start(8'hC2);
        wait_writes("t8", 159);
        idle(2);
        check("t8_wr_pending", {OamWrite, OamAddress}, {1'b1, 8'd159});
        start(8'hC4);
        check("t8_dropped", wr_cnt, 0);
        check("t8_busy", Busy, 1);
        wait_writes("t8", 160);
        check_xfer("t8", 8'hC4);

        rnd_mode = 1;
        for (int it = 0; it < 3; it++) begin
            logic [7:0] v;
            v = it == 0 ? 8'($urandom_range(224, 255)) : 8'($urandom);
            key = 8'($urandom);
            start(v);
            wait_writes("t7", 160);
            check("t7_busy_fall", Busy, 0);
            check("t7_regdout", RegDout, v);
            check_xfer("t7", v);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
